// File: rtl/meta_info_uart_streamer_pkg.sv
// Shared definitions for the meta-info UART streamer.
//   state_t         : FSM encoding (IDLE, SETTLE, SAMPLE, TX_START, TX_DATA,
//                     TX_STOP, ADVANCE, FINISH) used by the top and by
//                     uart_tx_byte.
//   ASCII_* consts  : terminator and line-ending characters.
//   UART_DATA_BITS  : data bits per 8N1 frame.
//   cnt_width()     : counter width for a cycle count, never below 1 bit.
package meta_uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    SAMPLE   = 3'd2,
    TX_START = 3'd3,
    TX_DATA  = 3'd4,
    TX_STOP  = 3'd5,
    ADVANCE  = 3'd6,
    FINISH   = 3'd7
  } state_t;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  localparam int UART_DATA_BITS = 8;

  // A count of n cycles needs $clog2(n) bits; n==1 still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/meta_info_uart_streamer_if.sv
// Bus bundle between the streamer, its requester and the character ROM.
//   start, proj_sel          : message request (requester -> streamer)
//   chr                      : ROM data for the current address (ROM -> streamer)
//   proj_idx, chr_idx        : ROM address (streamer -> ROM)
//   tx                       : UART serial line, idle high
//   busy, done, char_count   : message status
// modport master : requester/ROM side.  modport slave : the streamer.
interface meta_info_uart_streamer_if;
  logic       start;
  logic [5:0] proj_sel;
  logic [7:0] chr;
  logic [5:0] proj_idx;
  logic [5:0] chr_idx;
  logic       tx;
  logic       busy;
  logic       done;
  logic [5:0] char_count;

  modport master (
    output start, proj_sel, chr,
    input  proj_idx, chr_idx, tx, busy, done, char_count
  );

  modport slave (
    input  start, proj_sel, chr,
    output proj_idx, chr_idx, tx, busy, done, char_count
  );
endinterface

// File: rtl/meta_info_uart_streamer_uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer for one byte.
//   clock  : system clock, rising edge
//   reset  : synchronous, active low; line returns high on the next edge
//   load   : accepted only while ready is high; captures data
//   data   : byte to send, LSB first
//   tx     : registered serial output, idle high
//   ready  : high when no frame is in flight
// Each of start, 8 data and stop bits is held for CLKS_PER_BIT cycles.
module uart_tx_byte
  import meta_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int              BW        = cnt_width(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   BIT_ONE   = BW'(1'b1);
  localparam logic [2:0]      DATA_LAST = 3'(UART_DATA_BITS - 1);

  state_t          state_r, state_s;
  logic [BW-1:0]   bit_cnt_r, bit_cnt_s;
  logic [2:0]      bit_idx_r, bit_idx_s;
  logic [7:0]      shift_r, shift_s;
  logic            tx_r, tx_s;
  logic            ready_r, ready_s;
  logic            bit_end_s;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    tx_s      = tx_r;
    ready_s   = ready_r;
    bit_end_s = (bit_cnt_r == BIT_LAST);

    case (state_r)
      IDLE: begin
        if (load) begin
          shift_s   = data;
          tx_s      = 1'b0;
          bit_cnt_s = {BW{1'b0}};
          ready_s   = 1'b0;
          state_s   = TX_START;
        end else begin
          tx_s    = 1'b1;
          ready_s = 1'b1;
        end
      end
      TX_START: begin
        if (bit_end_s) begin
          bit_cnt_s = {BW{1'b0}};
          bit_idx_s = 3'd0;
          tx_s      = shift_r[0];
          shift_s   = {1'b0, shift_r[7:1]};
          state_s   = TX_DATA;
        end else begin
          bit_cnt_s = bit_cnt_r + BIT_ONE;
        end
      end
      TX_DATA: begin
        if (bit_end_s) begin
          bit_cnt_s = {BW{1'b0}};
          if (bit_idx_r == DATA_LAST) begin
            tx_s    = 1'b1;
            state_s = TX_STOP;
          end else begin
            tx_s      = shift_r[0];
            shift_s   = {1'b0, shift_r[7:1]};
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          bit_cnt_s = bit_cnt_r + BIT_ONE;
        end
      end
      TX_STOP: begin
        if (bit_end_s) begin
          bit_cnt_s = {BW{1'b0}};
          ready_s   = 1'b1;
          state_s   = IDLE;
        end else begin
          bit_cnt_s = bit_cnt_r + BIT_ONE;
        end
      end
      default: begin
        tx_s    = 1'b1;
        ready_s = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer registers; reset drops any frame in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= IDLE;
      bit_cnt_r <= {BW{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      tx_r      <= tx_s;
      ready_r   <= ready_s;
    end
  end

  assign tx    = tx_r;
  assign ready = ready_r;

endmodule

// File: rtl/meta_info_uart_streamer.sv
// meta_info_uart_streamer: walks a NUL-terminated string out of the
// meta-info character ROM and sends it on an 8N1 UART line.
//   clock  : system clock, rising edge
//   reset  : synchronous, active low; aborts any message immediately
//   bus    : meta_info_uart_streamer_if.slave
//            start/proj_sel request, chr from ROM, proj_idx/chr_idx to ROM,
//            tx line, busy, done pulse, char_count
// Optional: define META_UART_CRLF_EN to append CR LF after every message
// (including empty ones); char_count never counts them.
module meta_info_uart_streamer
  import meta_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_CHARS     = 63
) (
  input logic                         clock,
  input logic                         reset,
  meta_info_uart_streamer_if.slave    bus
);

  localparam int            SW          = cnt_width(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1'b1);
  localparam logic [5:0]    MAX_COUNT   = 6'(MAX_CHARS);

  state_t        state_r, state_s;
  logic [SW-1:0] settle_r, settle_s;
  logic [5:0]    proj_r, proj_s;
  logic [5:0]    chr_idx_r, chr_idx_s;
  logic [5:0]    char_count_r, char_count_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          load_s;
  logic [7:0]    load_data_s;
  logic          ready_s;
  logic          tx_s;
`ifdef META_UART_CRLF_EN
  logic          sfx_active_r, sfx_active_s;
  logic          sfx_idx_r, sfx_idx_s;
`endif

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clock (clock),
    .reset (reset),
    .load  (load_s),
    .data  (load_data_s),
    .tx    (tx_s),
    .ready (ready_s)
  );

  // Message walker: next-state, address and status logic.
  always_comb begin
    state_s      = state_r;
    settle_s     = settle_r;
    proj_s       = proj_r;
    chr_idx_s    = chr_idx_r;
    char_count_s = char_count_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    load_s       = 1'b0;
    load_data_s  = bus.chr;
`ifdef META_UART_CRLF_EN
    sfx_active_s = sfx_active_r;
    sfx_idx_s    = sfx_idx_r;
`endif

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          proj_s       = bus.proj_sel;
          chr_idx_s    = 6'd0;
          char_count_s = 6'd0;
          busy_s       = 1'b1;
          settle_s     = SETTLE_LOAD;
          state_s      = SETTLE;
`ifdef META_UART_CRLF_EN
          sfx_active_s = 1'b0;
          sfx_idx_s    = 1'b0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE: begin
        if (settle_r == {SW{1'b0}}) begin
          state_s = SAMPLE;
        end else begin
          settle_s = settle_r - SETTLE_ONE;
        end
      end
      SAMPLE: begin
        if ((bus.chr == ASCII_NUL) || (char_count_r == MAX_COUNT)) begin
`ifdef META_UART_CRLF_EN
          load_s       = 1'b1;
          load_data_s  = ASCII_CR;
          sfx_active_s = 1'b1;
          sfx_idx_s    = 1'b0;
          state_s      = TX_START;
`else
          state_s = FINISH;
`endif
        end else begin
          load_s      = 1'b1;
          load_data_s = bus.chr;
          state_s     = TX_START;
        end
      end
      // The serializer sequences start/data/stop itself; this state just
      // waits for it to report the frame finished.
      TX_START: begin
        if (ready_s) begin
`ifdef META_UART_CRLF_EN
          if (sfx_active_r) begin
            if (sfx_idx_r == 1'b0) begin
              load_s      = 1'b1;
              load_data_s = ASCII_LF;
              sfx_idx_s   = 1'b1;
            end else begin
              state_s = FINISH;
            end
          end else begin
            char_count_s = char_count_r + 6'd1;
            state_s      = ADVANCE;
          end
`else
          char_count_s = char_count_r + 6'd1;
          state_s      = ADVANCE;
`endif
        end else begin
          state_s = TX_START;
        end
      end
      ADVANCE: begin
        // Cannot wrap: SAMPLE stops at MAX_CHARS <= 63 first.
        chr_idx_s = chr_idx_r + 6'd1;
        settle_s  = SETTLE_LOAD;
        state_s   = SETTLE;
      end
      FINISH: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // Walker registers; done is registered so it pulses the cycle after FINISH.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= IDLE;
      settle_r     <= {SW{1'b0}};
      proj_r       <= 6'd0;
      chr_idx_r    <= 6'd0;
      char_count_r <= 6'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
`ifdef META_UART_CRLF_EN
      sfx_active_r <= 1'b0;
      sfx_idx_r    <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      settle_r     <= settle_s;
      proj_r       <= proj_s;
      chr_idx_r    <= chr_idx_s;
      char_count_r <= char_count_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
`ifdef META_UART_CRLF_EN
      sfx_active_r <= sfx_active_s;
      sfx_idx_r    <= sfx_idx_s;
`endif
    end
  end

  assign bus.proj_idx   = proj_r;
  assign bus.chr_idx    = chr_idx_r;
  assign bus.tx         = tx_s;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.char_count = char_count_r;

endmodule

// File: tb/tb_meta_info_uart_streamer.sv
// Testbench for meta_info_uart_streamer: ROM model, UART frame decoder and
// scoreboard of expected frames and end-of-message status.
module tb_meta_info_uart_streamer;

  localparam int CPB    = 4;
  localparam int SETTLE = 8;
  localparam int MAXC   = 63;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  meta_info_uart_streamer_if bus();

  meta_info_uart_streamer #(
    .CLKS_PER_BIT  (CPB),
    .SETTLE_CYCLES (SETTLE),
    .MAX_CHARS     (MAXC)
  ) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int count;
    int idx;
    int proj;
  } done_exp_t;

  logic [7:0] rom [0:63][0:63];
  logic [7:0] exp_frames [$];
  done_exp_t  exp_done [$];
  int n_checks  = 0;
  int n_pass    = 0;
  int done_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // ROM: data follows the address presented by the DUT.
  always @(negedge clk) bus.chr = rom[bus.proj_idx][bus.chr_idx];

  // Reference model: the string up to NUL or MAXC chars, optional CR LF.
  task automatic expect_msg(input int p);
    int n;
    n = 0;
    while (n < MAXC && rom[p][n] != 8'h00) begin
      exp_frames.push_back(rom[p][n]);
      n++;
    end
`ifdef META_UART_CRLF_EN
    exp_frames.push_back(8'h0D);
    exp_frames.push_back(8'h0A);
`endif
    exp_done.push_back('{n, n, p});
  endtask

  // UART decoder: samples mid-bit, checks framing and scoreboard order.
  int         dec_t;
  logic       dec_on = 1'b0;
  logic [7:0] dec_byte;
  always @(negedge clk) begin
    if (!reset) begin
      dec_on = 1'b0;
    end else if (!dec_on) begin
      if (bus.tx == 1'b0) begin
        dec_on = 1'b1;
        dec_t  = 0;
      end
    end else begin
      dec_t++;
      if (dec_t == CPB/2) begin
        check("start_bit", int'(bus.tx), 0);
      end else if (dec_t > CPB/2 && dec_t < CPB/2 + 9*CPB && ((dec_t - CPB/2) % CPB) == 0) begin
        dec_byte[(dec_t - CPB/2)/CPB - 1] = bus.tx;
      end else if (dec_t == CPB/2 + 9*CPB) begin
        check("stop_bit", int'(bus.tx), 1);
        if (exp_frames.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame: got 0x%02h expected no frame", dec_byte);
        end else begin
          check("frame", int'(dec_byte), int'(exp_frames.pop_front()));
        end
        dec_on = 1'b0;
      end
    end
  end

  // Done monitor: compares the end-of-message status.
  always @(negedge clk) begin
    if (reset && bus.done) begin
      done_exp_t e;
      done_seen++;
      if (exp_done.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        e = exp_done.pop_front();
        check("char_count", int'(bus.char_count), e.count);
        check("chr_idx_at_done", int'(bus.chr_idx), e.idx);
        check("proj_idx_at_done", int'(bus.proj_idx), e.proj);
        check("busy_at_done", int'(bus.busy), 0);
        check("frames_left_at_done", exp_frames.size(), 0);
      end
    end
  end

  // Issue one message; lat = edges from the accepting edge to done visible.
  task automatic run_msg(input int p, input bit repulse, output int lat);
    int target;
    bit got;
    expect_msg(p);
    target = done_seen + 1;
    got    = 1'b0;
    lat    = 0;
    @(posedge clk); #1;
    bus.proj_sel = 6'(p);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
    for (int n = 1; n <= 6000; n++) begin
      @(posedge clk); #1;
      if (repulse && n == 30) begin
        bus.proj_sel = 6'd9;
        bus.start    = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = n;
        got = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL done_timeout: got no done expected done within 6000 cycles");
    end
    @(negedge clk); #1;
    check("done_pulses", done_seen, target);
    repeat (3) @(posedge clk);
  endtask

  // Abort a message during data bit 3 of 'H' and check the reset state.
  task automatic reset_mid();
    bit low;
    low = 1'b0;
    expect_msg(5);
    @(posedge clk); #1;
    bus.proj_sel = 6'd5;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (bus.tx == 1'b0) begin
        low = 1'b1;
        break;
      end
    end
    if (!low) begin
      n_checks++;
      $display("FAIL frame_start_timeout: got tx=1 expected a start bit");
    end
    repeat (CPB*4 + 1) @(posedge clk);
    #1;
    check("tx_data_bit3", int'(bus.tx), 1);
    reset = 1'b0;
    exp_frames.delete();
    exp_done.delete();
    @(posedge clk); #1;
    check("abort_tx", int'(bus.tx), 1);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_chr_idx", int'(bus.chr_idx), 0);
    check("abort_char_count", int'(bus.char_count), 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int lat;
    int len;
    int p;
    bus.start    = 1'b0;
    bus.proj_sel = 6'd0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        rom[i][j] = 8'h00;
    rom[5][0] = 8'h48;
    rom[5][1] = 8'h69;
    for (int j = 0; j < 64; j++) rom[7][j] = 8'($urandom_range(1, 255));
    for (int j = 0; j < 4; j++) rom[9][j] = 8'h5A;
    for (int i = 10; i <= 20; i++) begin
      len = $urandom_range(0, 12);
      for (int j = 0; j < len; j++) rom[i][j] = 8'($urandom_range(1, 255));
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", int'(bus.tx), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_proj_idx", int'(bus.proj_idx), 0);
    check("rst_chr_idx", int'(bus.chr_idx), 0);
    check("rst_char_count", int'(bus.char_count), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_msg(5, 1'b0, lat);
    run_msg(3, 1'b0, lat);
`ifndef META_UART_CRLF_EN
    check("empty_done_latency", lat, SETTLE + 2);
`endif
    run_msg(7, 1'b0, lat);
    run_msg(5, 1'b1, lat);
    reset_mid();
    run_msg(5, 1'b0, lat);
    for (int k = 0; k < 6; k++) begin
      p = $urandom_range(10, 20);
      run_msg(p, 1'b0, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
